// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared constants and types for the SPI register peripheral: frame geometry,
// bit-counter saturation value, register map addresses and register count.
// -----------------------------------------------------------------------------
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;
    localparam int CNT_BITS   = 5;

    // Counter stops here so an overrun frame can never wrap back to 16.
    localparam logic [CNT_BITS-1:0] CNT_SAT  = 5'd17;
    localparam logic [CNT_BITS-1:0] CNT_FULL = 5'd16;

    // Register map
    localparam logic [ADDR_BITS-1:0] ADDR_EN_REG_OUT_7_0  = 7'h00;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_REG_OUT_15_8 = 7'h01;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_REG_PWM_7_0  = 7'h02;
    localparam logic [ADDR_BITS-1:0] ADDR_EN_REG_PWM_15_8 = 7'h03;
    localparam logic [ADDR_BITS-1:0] ADDR_PWM_DUTY_CYCLE  = 7'h04;

    localparam int NUM_REGS = 5;

    // Frame layout as it sits in the shift register after 16 bits (MSB first).
    typedef struct packed {
        logic                 wr;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } frame_t;

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Multi-flop synchroniser for one asynchronous input, followed by one extra
// flop that provides single-cycle rising/falling edge pulses.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (all flops load RESET_VAL)
//   d     - asynchronous input
//   q     - synchronised level
//   rise  - one-clk pulse when q goes 0->1
//   fall  - one-clk pulse when q goes 1->0
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= {STAGES{RESET_VAL}};
            prev_reg  <= RESET_VAL;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
            prev_reg  <= chain_reg[STAGES-1];
        end
    end

    assign q    = chain_reg[STAGES-1];
    assign rise =  q & ~prev_reg;
    assign fall = ~q &  prev_reg;

endmodule

// File: rtl/spi_peripheral.sv
// -----------------------------------------------------------------------------
// spi_peripheral
// Write-only SPI mode-0 register peripheral. Frames are 16 bits, MSB first:
// {wr, addr[6:0], data[7:0]}. A frame is committed on the ncs rising edge only
// when exactly 16 bits were clocked, wr=1 and addr < NUM_REGS.
// Ports:
//   clk, rst_n          - system clock, asynchronous active-low reset
//   sclk, copi, ncs     - asynchronous SPI inputs (synchronised internally)
//   en_reg_out_7_0      - register 0x00
//   en_reg_out_15_8     - register 0x01
//   en_reg_pwm_7_0      - register 0x02
//   en_reg_pwm_15_8     - register 0x03
//   pwm_duty_cycle      - register 0x04
//   wr_strobe           - one-clk pulse on each committed write
// -----------------------------------------------------------------------------
module spi_peripheral
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = spi_reg_pkg::NUM_REGS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    localparam int OUT_REGS = 5;

    // ---------------- input synchronisers ----------------
    logic sclk_rise;
    logic unused_sclk_q;
    logic unused_sclk_fall;
    logic ncs_q;
    logic ncs_rise;
    logic ncs_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sclk),
        .q    (unused_sclk_q),
        .rise (sclk_rise),
        .fall (unused_sclk_fall)
    );

    // ncs resets high so leaving reset does not look like a frame start.
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ncs),
        .q    (ncs_q),
        .rise (ncs_rise),
        .fall (ncs_fall)
    );

    // copi needs only the level; same depth as sclk keeps them aligned.
    logic [SYNC_STAGES-1:0] copi_sync_reg;
    logic                   copi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copi_sync_reg <= '0;
        end else begin
            copi_sync_reg <= {copi_sync_reg[SYNC_STAGES-2:0], copi};
        end
    end

    assign copi_q = copi_sync_reg[SYNC_STAGES-1];

    // ---------------- shift register and bit counter ----------------
    logic [FRAME_BITS-1:0] shift_reg;
    logic [CNT_BITS-1:0]   bit_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (ncs_fall) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (sclk_rise && !ncs_q) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_q};
            if (bit_cnt_reg != CNT_SAT) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    // ---------------- commit decode ----------------
    frame_t               frame;
    logic                 addr_ok;
    logic                 commit;
    logic [NUM_REGS-1:0]  reg_we;

    assign frame   = frame_t'(shift_reg);
    assign addr_ok = (32'(frame.addr) < 32'(NUM_REGS));
    // Commit uses the frame as it stands on the ncs-rise cycle, so a following
    // ncs fall (which clears the shifter later) cannot disturb it.
    assign commit  = ncs_rise && (bit_cnt_reg == CNT_FULL) && frame.wr && addr_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
            assign reg_we[gi] = commit && (frame.addr == ADDR_BITS'(gi));
        end
    endgenerate

    // ---------------- register file ----------------
    logic [DATA_BITS-1:0] regs_reg [NUM_REGS];
    logic                 wr_strobe_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
            wr_strobe_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_we[i]) begin
                    regs_reg[i] <= frame.data;
                end
            end
            wr_strobe_reg <= commit;
        end
    end

    // Registers not present for small NUM_REGS read as zero.
    logic [DATA_BITS-1:0] out_val [OUT_REGS];

    generate
        for (gi = 0; gi < OUT_REGS; gi++) begin : g_out
            if (gi < NUM_REGS) begin : g_present
                assign out_val[gi] = regs_reg[gi];
            end else begin : g_absent
                assign out_val[gi] = '0;
            end
        end
    endgenerate

    assign en_reg_out_7_0  = out_val[0];
    assign en_reg_out_15_8 = out_val[1];
    assign en_reg_pwm_7_0  = out_val[2];
    assign en_reg_pwm_15_8 = out_val[3];
    assign pwm_duty_cycle  = out_val[4];
    assign wr_strobe       = wr_strobe_reg;

endmodule

// File: tb/tb_spi_peripheral.sv
// -----------------------------------------------------------------------------
// tb_spi_peripheral
// Self-checking bench: directed frames for the listed scenarios followed by
// randomised frames, checked against a register-map model in the bench.
// -----------------------------------------------------------------------------
module tb_spi_peripheral;
    import spi_reg_pkg::*;

    localparam int SS       = 2;       // SYNC_STAGES
    localparam int HOLD     = SS + 4;  // sclk phase length in clk cycles
    localparam int NCS_HOLD = SS + 2;  // minimum ncs high time

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;

    spi_peripheral #(.SYNC_STAGES(SS), .NUM_REGS(NUM_REGS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sclk           (sclk),
        .copi           (copi),
        .ncs            (ncs),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .wr_strobe      (wr_strobe)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    int         strobe_cnt  = 0;
    int         exp_strobes = 0;
    logic [7:0] model_regs [5];

    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s reg%0d", tag, i), dut_reg(i), model_regs[i]);
        end
        check($sformatf("%s strobe_count", tag), strobe_cnt, exp_strobes);
    endtask

    task automatic clock_bit(input logic b);
        copi = b;
        wait_cyc(HOLD);
        sclk = 1'b1;
        wait_cyc(HOLD);
        sclk = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge after the minimum ncs-high time.
    task automatic send_frame(input logic [15:0] frame, input int nbits, input logic extra_bit);
        logic       do_commit;
        logic [6:0] addr;
        logic [7:0] data;
        addr = frame[14:8];
        data = frame[7:0];
        ncs = 1'b0;
        wait_cyc(HOLD);
        for (int i = 0; i < nbits; i++) begin
            clock_bit((i < 16) ? frame[15 - i] : extra_bit);
        end
        wait_cyc(HOLD);
        do_commit = (nbits == 16) && frame[15] && (int'(addr) < NUM_REGS);
        if (do_commit) begin
            model_regs[addr] = data;
            exp_strobes++;
        end
        ncs = 1'b1;
        repeat (SS) @(posedge clk);
        #1 check($sformatf("frame %04h/%0d strobe_early", frame, nbits), wr_strobe, 1'b0);
        @(posedge clk);
        #1 check($sformatf("frame %04h/%0d strobe", frame, nbits), wr_strobe, do_commit);
        if (do_commit) begin
            check($sformatf("frame %04h latency", frame), dut_reg(int'(addr)), data);
        end
        @(negedge clk);
        wait_cyc(NCS_HOLD - SS - 1);
        $display("frame %04h bits=%0d commit=%0d", frame, nbits, do_commit);
        check_all($sformatf("frame %04h", frame));
    endtask

    initial begin
        int         nb;
        int         r;
        logic [6:0] a;
        logic [15:0] f;
        int         base;

        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
        wait_cyc(5);
        check_all("in reset");
        check("in reset wr_strobe", wr_strobe, 1'b0);
        rst_n = 1'b1;
        wait_cyc(5);
        check_all("after reset");

        // single writes
        send_frame({1'b1, ADDR_EN_REG_OUT_7_0, 8'hF0}, 16, 1'b0);
        send_frame({1'b1, ADDR_PWM_DUTY_CYCLE, 8'h80}, 16, 1'b0);

        // read frame and out-of-range address are ignored
        send_frame(16'h00AA, 16, 1'b0);
        send_frame(16'h90FF, 16, 1'b0);

        // short and overrun frames are discarded
        send_frame({1'b1, ADDR_EN_REG_OUT_15_8, 8'h55}, 15, 1'b0);
        send_frame({1'b1, ADDR_EN_REG_OUT_15_8, 8'h55}, 17, 1'b1);

        // reset mid-frame after 8 bits of 0x83CC
        f = 16'h83CC;
        ncs = 1'b0;
        wait_cyc(HOLD);
        for (int i = 0; i < 8; i++) clock_bit(f[15 - i]);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
        #1 check_all("async reset");
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(HOLD);
        ncs = 1'b1;
        wait_cyc(HOLD);
        check_all("post reset");
        send_frame({1'b1, ADDR_EN_REG_PWM_15_8, 8'h11}, 16, 1'b0);

        // back-to-back writes with minimum ncs high time
        base = strobe_cnt;
        send_frame({1'b1, ADDR_EN_REG_PWM_7_0, 8'h01}, 16, 1'b0);
        send_frame({1'b1, ADDR_EN_REG_PWM_7_0, 8'h02}, 16, 1'b0);
        check("back_to_back strobes", strobe_cnt - base, 2);

        // same value again still strobes
        send_frame({1'b1, ADDR_EN_REG_PWM_7_0, 8'h02}, 16, 1'b0);

        // randomised frames
        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 4);
            nb = (r == 0) ? 15 : (r == 4) ? 17 : 16;
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                             : 7'($urandom_range(0, 5));
            f  = {($urandom_range(0, 3) != 0), a, 8'($urandom_range(0, 255))};
            send_frame(f, nb, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
